// File: rtl/collision_event_gen_if.sv
// Frog/car position bus into the collision event generator and the hit/grace
// event outputs back to the game state machine and display path.
interface collision_event_gen_if;
    logic       i_Frame_Tick;
    logic       i_Game_Active;
    logic [9:0] i_Frog_X;
    logic [8:0] i_Frog_Y;
    logic [9:0] i_Car_X_0;
    logic [9:0] i_Car_X_1;
    logic [9:0] i_Car_X_2;
    logic [9:0] i_Car_X_3;
    logic [9:0] i_Car_X_4;
    logic       o_Hit_Pulse;
    logic [2:0] o_Hit_Lane;
    logic       o_Grace_Active;
    logic       o_Blink;

    modport master (
        output i_Frame_Tick, i_Game_Active, i_Frog_X, i_Frog_Y,
        output i_Car_X_0, i_Car_X_1, i_Car_X_2, i_Car_X_3, i_Car_X_4,
        input  o_Hit_Pulse, o_Hit_Lane, o_Grace_Active, o_Blink
    );

    modport slave (
        input  i_Frame_Tick, i_Game_Active, i_Frog_X, i_Frog_Y,
        input  i_Car_X_0, i_Car_X_1, i_Car_X_2, i_Car_X_3, i_Car_X_4,
        output o_Hit_Pulse, o_Hit_Lane, o_Grace_Active, o_Blink
    );
endinterface

// File: rtl/collision_event_gen.sv
// Frog vs. lane-car collision -> one hit pulse, frame-counted grace, re-arm on separation.
// Latency: 2 clocks inputs -> o_Hit_Pulse; no backpressure (event output, never stalls).
// Optional sprite blink during grace when COLLISION_BLINK_EN is defined.
module collision_event_gen #(
    parameter int TILE_SIZE    = 32,
    parameter int C_LINE_1_Y   = 64,
    parameter int C_LINE_2_Y   = 128,
    parameter int C_LINE_3_Y   = 192,
    parameter int C_LINE_4_Y   = 256,
    parameter int C_LINE_5_Y   = 320,
    parameter int GRACE_FRAMES = 60,
    parameter int BLINK_HALF   = 4
) (
    input  logic i_Clk,
    input  logic i_Reset,
    collision_event_gen_if.slave bus
);

    localparam int CNT_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam logic [10:0] TILE = 11'(TILE_SIZE);
    localparam logic [8:0] LANE_Y [5] = '{9'(C_LINE_1_Y), 9'(C_LINE_2_Y), 9'(C_LINE_3_Y),
                                          9'(C_LINE_4_Y), 9'(C_LINE_5_Y)};

    if (TILE_SIZE < 1 || GRACE_FRAMES < 0 || BLINK_HALF < 1) begin : g_param_check
        $error("collision_event_gen: TILE_SIZE/BLINK_HALF must be >= 1, GRACE_FRAMES >= 0");
    end

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GRACE, S_WAIT_CLR} state_t;

    logic [9:0]       car_x [5];
    logic [4:0]       overlap_d, r_Overlap;
    logic             r_Any;
    logic [2:0]       lowest_lane;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic [2:0]       lane_q, lane_d;

    assign car_x[0] = bus.i_Car_X_0;
    assign car_x[1] = bus.i_Car_X_1;
    assign car_x[2] = bus.i_Car_X_2;
    assign car_x[3] = bus.i_Car_X_3;
    assign car_x[4] = bus.i_Car_X_4;

    // Sums carried in 11 bits so cars near the right edge cannot wrap to a false miss.
    always_comb begin
        overlap_d = '0;
        for (int k = 0; k < 5; k++) begin
            overlap_d[k] = (bus.i_Frog_Y == LANE_Y[k])
                        && ({1'b0, bus.i_Frog_X} < {1'b0, car_x[k]} + TILE)
                        && ({1'b0, car_x[k]} < {1'b0, bus.i_Frog_X} + TILE);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) r_Overlap <= '0;
        else         r_Overlap <= overlap_d;
    end

    assign r_Any = |r_Overlap;

    always_comb begin
        lowest_lane = 3'd7;
        for (int k = 4; k >= 0; k--) begin
            if (r_Overlap[k]) lowest_lane = 3'(k);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            lane_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.i_Game_Active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     state_d = S_ARMED;
                S_ARMED:    if (r_Any) state_d = (GRACE_FRAMES == 0) ? S_WAIT_CLR : S_GRACE;
                S_GRACE:    if (bus.i_Frame_Tick && cnt_q == CNT_W'(1)) state_d = S_WAIT_CLR;
                S_WAIT_CLR: if (!r_Any) state_d = S_ARMED;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Entry into grace loads the full count, so a coincident frame tick is not consumed.
    always_comb begin
        pulse_d = (state_q == S_ARMED) && bus.i_Game_Active && r_Any;
        lane_d  = pulse_d ? lowest_lane : lane_q;
        cnt_d   = cnt_q;
        if (!bus.i_Game_Active)
            cnt_d = '0;
        else if (pulse_d)
            cnt_d = CNT_W'(GRACE_FRAMES);
        else if (state_q == S_GRACE && bus.i_Frame_Tick && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    assign bus.o_Hit_Pulse    = pulse_q;
    assign bus.o_Hit_Lane     = lane_q;
    assign bus.o_Grace_Active = (state_q == S_GRACE);

`ifdef COLLISION_BLINK_EN
    localparam int BCNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BCNT_W-1:0] bcnt_q;
    logic              blink_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || state_d != S_GRACE) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (state_q != S_GRACE) begin
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else if (bus.i_Frame_Tick) begin
            if (bcnt_q == BCNT_W'(BLINK_HALF - 1)) begin
                bcnt_q  <= '0;
                blink_q <= ~blink_q;
            end else begin
                bcnt_q  <= bcnt_q + BCNT_W'(1);
            end
        end
    end

    assign bus.o_Blink = blink_q;
`else
    assign bus.o_Blink = 1'b0;
`endif

endmodule

// File: tb/tb_collision_event_gen.sv
// Directed bench: main DUT (GRACE_FRAMES=3), a zero-grace DUT with lanes 2/4 sharing a Y,
// and (with COLLISION_BLINK_EN) a blink DUT with GRACE_FRAMES=8, BLINK_HALF=2.
module tb_collision_event_gen;
    logic i_Clk = 1'b0;
    logic i_Reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 i_Clk = ~i_Clk;

    collision_event_gen_if ifm ();
    collision_event_gen_if ifz ();

    assign ifz.i_Frame_Tick  = ifm.i_Frame_Tick;
    assign ifz.i_Game_Active = ifm.i_Game_Active;
    assign ifz.i_Frog_X      = ifm.i_Frog_X;
    assign ifz.i_Frog_Y      = ifm.i_Frog_Y;
    assign ifz.i_Car_X_0     = ifm.i_Car_X_0;
    assign ifz.i_Car_X_1     = ifm.i_Car_X_1;
    assign ifz.i_Car_X_2     = ifm.i_Car_X_2;
    assign ifz.i_Car_X_3     = ifm.i_Car_X_3;
    assign ifz.i_Car_X_4     = ifm.i_Car_X_4;

    collision_event_gen #(.GRACE_FRAMES(3)) u_main (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(ifm));
    collision_event_gen #(.GRACE_FRAMES(0), .C_LINE_5_Y(192))
        u_zero (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(ifz));

`ifdef COLLISION_BLINK_EN
    collision_event_gen_if ifb ();
    assign ifb.i_Frame_Tick  = ifm.i_Frame_Tick;
    assign ifb.i_Game_Active = ifm.i_Game_Active;
    assign ifb.i_Frog_X      = ifm.i_Frog_X;
    assign ifb.i_Frog_Y      = ifm.i_Frog_Y;
    assign ifb.i_Car_X_0     = ifm.i_Car_X_0;
    assign ifb.i_Car_X_1     = ifm.i_Car_X_1;
    assign ifb.i_Car_X_2     = ifm.i_Car_X_2;
    assign ifb.i_Car_X_3     = ifm.i_Car_X_3;
    assign ifb.i_Car_X_4     = ifm.i_Car_X_4;
    collision_event_gen #(.GRACE_FRAMES(8), .BLINK_HALF(2))
        u_blink (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(ifb));
    localparam logic BLINK_ON_GRACE = 1'b1;
`else
    localparam logic BLINK_ON_GRACE = 1'b0;
`endif

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic frame_tick();
        ifm.i_Frame_Tick = 1'b1;
        step();
        ifm.i_Frame_Tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        i_Reset           = 1'b1;
        ifm.i_Frame_Tick  = 1'b0;
        ifm.i_Game_Active = 1'b0;
        ifm.i_Frog_X      = 10'd0;
        ifm.i_Frog_Y      = 9'd0;
        ifm.i_Car_X_0     = 10'd600;
        ifm.i_Car_X_1     = 10'd600;
        ifm.i_Car_X_2     = 10'd600;
        ifm.i_Car_X_3     = 10'd600;
        ifm.i_Car_X_4     = 10'd600;
        step();
        step();
        chk("rst_pulse", 32'(ifm.o_Hit_Pulse), 0);
        chk("rst_lane",  32'(ifm.o_Hit_Lane), 7);
        chk("rst_grace", 32'(ifm.o_Grace_Active), 0);
        chk("rst_blink", 32'(ifm.o_Blink), 0);

        // Activate, then frog (100,128) vs car_1 at 110
        i_Reset = 1'b0;
        ifm.i_Game_Active = 1'b1;
        step();
        step();
        ifm.i_Frog_X  = 10'd100;
        ifm.i_Frog_Y  = 9'd128;
        ifm.i_Car_X_1 = 10'd110;
        step();
        chk("hit_lat1_pulse", 32'(ifm.o_Hit_Pulse), 0);
        step();
        chk("hit_pulse", 32'(ifm.o_Hit_Pulse), 1);
        chk("hit_lane",  32'(ifm.o_Hit_Lane), 1);
        chk("hit_grace", 32'(ifm.o_Grace_Active), 1);
        chk("z_hit_pulse", 32'(ifz.o_Hit_Pulse), 1);
        chk("z_hit_grace", 32'(ifz.o_Grace_Active), 0);
        step();
        chk("hit_single", 32'(ifm.o_Hit_Pulse), 0);
        chk("grace_hold", 32'(ifm.o_Grace_Active), 1);
        chk("grace_blink", 32'(ifm.o_Blink), 32'(BLINK_ON_GRACE));
        chk("z_no_rehit", 32'(ifz.o_Hit_Pulse), 0);
        chk("z_grace", 32'(ifz.o_Grace_Active), 0);

        // Three frame ticks with overlap held
        frame_tick();
        chk("tick1_grace", 32'(ifm.o_Grace_Active), 1);
        frame_tick();
        chk("tick2_grace", 32'(ifm.o_Grace_Active), 1);
        chk("tick2_pulse", 32'(ifm.o_Hit_Pulse), 0);
        frame_tick();
        chk("tick3_grace", 32'(ifm.o_Grace_Active), 0);
        chk("tick3_blink", 32'(ifm.o_Blink), 0);
        step();
        step();
        chk("waitclr_pulse", 32'(ifm.o_Hit_Pulse), 0);

        // Gap 0 separates and re-arms without a hit; 131 hits
        ifm.i_Car_X_1 = 10'd132;
        step();
        step();
        step();
        step();
        chk("gap0_pulse", 32'(ifm.o_Hit_Pulse), 0);
        ifm.i_Car_X_1 = 10'd131;
        step();
        step();
        chk("rearm_pulse", 32'(ifm.o_Hit_Pulse), 1);
        chk("rearm_lane",  32'(ifm.o_Hit_Lane), 1);

        // Deactivate mid-grace
        ifm.i_Game_Active = 1'b0;
        step();
        chk("deact_grace", 32'(ifm.o_Grace_Active), 0);
        chk("deact_lane",  32'(ifm.o_Hit_Lane), 1);
        ifm.i_Frog_X  = 10'd0;
        ifm.i_Car_X_1 = 10'd1000;
        ifm.i_Game_Active = 1'b1;
        step();
        step();
        step();
        chk("react_pulse", 32'(ifm.o_Hit_Pulse), 0);
        chk("react_lane",  32'(ifm.o_Hit_Lane), 1);
        chk("react_grace", 32'(ifm.o_Grace_Active), 0);

        // Hit coincident with deactivation: no pulse
        ifm.i_Car_X_1 = 10'd10;
        step();
        ifm.i_Game_Active = 1'b0;
        step();
        chk("deact_win_pulse", 32'(ifm.o_Hit_Pulse), 0);
        step();
        chk("deact_win_pulse2", 32'(ifm.o_Hit_Pulse), 0);

        // Lanes 2 and 4 overlap together (lane 4 shares Y=192 on u_zero)
        ifm.i_Frog_X  = 10'd200;
        ifm.i_Frog_Y  = 9'd192;
        ifm.i_Car_X_1 = 10'd600;
        ifm.i_Car_X_2 = 10'd210;
        ifm.i_Car_X_4 = 10'd220;
        ifm.i_Game_Active = 1'b1;
        step();
        step();
        chk("multi_pulse",   32'(ifm.o_Hit_Pulse), 1);
        chk("multi_lane",    32'(ifm.o_Hit_Lane), 2);
        chk("z_multi_pulse", 32'(ifz.o_Hit_Pulse), 1);
        chk("z_multi_lane",  32'(ifz.o_Hit_Lane), 2);
        step();
        chk("z_multi_single", 32'(ifz.o_Hit_Pulse), 0);

        // Right-edge car: 1000 vs 1010 must not wrap the 10-bit sum
        ifm.i_Game_Active = 1'b0;
        step();
        ifm.i_Frog_X  = 10'd1000;
        ifm.i_Frog_Y  = 9'd64;
        ifm.i_Car_X_2 = 10'd600;
        ifm.i_Car_X_4 = 10'd600;
        ifm.i_Game_Active = 1'b1;
        step();
        step();
        step();
        chk("edge_quiet", 32'(ifm.o_Hit_Pulse), 0);
        ifm.i_Car_X_0 = 10'd1010;
        step();
        step();
        chk("edge_pulse", 32'(ifm.o_Hit_Pulse), 1);
        chk("edge_lane",  32'(ifm.o_Hit_Lane), 0);

        // Reset mid-grace
        i_Reset = 1'b1;
        step();
        chk("midrst_pulse", 32'(ifm.o_Hit_Pulse), 0);
        chk("midrst_lane",  32'(ifm.o_Hit_Lane), 7);
        chk("midrst_grace", 32'(ifm.o_Grace_Active), 0);

`ifdef COLLISION_BLINK_EN
        begin
            logic exp_blink [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            i_Reset = 1'b0;
            step();
            step();
            chk("b_pulse", 32'(ifb.o_Hit_Pulse), 1);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("blink%0d", i), 32'(ifb.o_Blink), 32'(exp_blink[i]));
                frame_tick();
            end
            chk("blink_after", 32'(ifb.o_Blink), 0);
            chk("b_grace_after", 32'(ifb.o_Grace_Active), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
